// File: rtl/tdm_mux_16_1.sv
// Time-division N:1 serializer: captures a parallel frame of NUM_CH lanes in one
// handshake and emits one lane per enabled clock, tagged with its slot index.
module tdm_mux_16_1 #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned DATA_W = 1
) (
  input  logic                     Clock_In,
  input  logic                     Reset_In,
  input  logic                     Enable_In,
  input  logic                     Load_In,
  input  logic [NUM_CH*DATA_W-1:0] Data_In,
  output logic                     Ready_Out,
  output logic [DATA_W-1:0]        Data_Out,
  output logic [SEL_W-1:0]         Select_Out,
  output logic                     Valid_Out,
  output logic                     Frame_Start_Out,
  output logic                     Frame_End_Out,
  output logic                     Overrun_Out
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_CH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                     state;
  logic [NUM_CH*DATA_W-1:0]   shadow;
  logic [SEL_W-1:0]           next_sel;
  logic [DATA_W-1:0]          next_lane;
  logic                       last_slot;
  logic                       accept;

  // Select_Out doubles as the slot counter; a new frame may be taken in the last slot.
  assign last_slot = (Select_Out == LAST_SLOT);
  assign Ready_Out = Enable_In & ~Reset_In &
                     ((state == IDLE) | ((state == SHIFT) & last_slot));
  assign accept    = Load_In & Ready_Out;
  assign next_sel  = Select_Out + SEL_W'(1);

  // Lane of the shadow frame that will be emitted in the following slot.
  always_comb begin
    next_lane = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (next_sel == SEL_W'(k)) begin
        next_lane = shadow[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state           <= IDLE;
      shadow          <= '0;
      Data_Out        <= '0;
      Select_Out      <= '0;
      Valid_Out       <= 1'b0;
      Frame_Start_Out <= 1'b0;
      Frame_End_Out   <= 1'b0;
      Overrun_Out     <= 1'b0;
    end else begin
      Overrun_Out <= Load_In & ~Ready_Out;
      if (accept) begin
        state           <= SHIFT;
        shadow          <= Data_In;
        Select_Out      <= '0;
        Data_Out        <= Data_In[DATA_W-1:0];
        Valid_Out       <= 1'b1;
        Frame_Start_Out <= 1'b1;
        Frame_End_Out   <= 1'b0;
      end else begin
        case (state)
          SHIFT: begin
            if (!Enable_In) begin
              // Pause: hold slot and data, suppress the qualifiers.
              Valid_Out       <= 1'b0;
              Frame_Start_Out <= 1'b0;
              Frame_End_Out   <= 1'b0;
            end else if (last_slot) begin
              state           <= IDLE;
              Valid_Out       <= 1'b0;
              Frame_Start_Out <= 1'b0;
              Frame_End_Out   <= 1'b0;
            end else begin
              Select_Out      <= next_sel;
              Data_Out        <= next_lane;
              Valid_Out       <= 1'b1;
              Frame_Start_Out <= 1'b0;
              Frame_End_Out   <= (next_sel == LAST_SLOT);
            end
          end
          default: begin
            Valid_Out       <= 1'b0;
            Frame_Start_Out <= 1'b0;
            Frame_End_Out   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux_16_1.sv
// Scoreboard bench for tdm_mux_16_1: stimulus pushes expected slots, a negedge
// monitor pops them and rebuilds frames through a behavioural 1:16 demux.
module tb_tdm_mux_16_1;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned DATA_W = 1;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             data;
    logic             fs;
    logic             fe;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              load;
  logic [NUM_CH-1:0] data_in;
  logic              ready;
  logic              data_out;
  logic [SEL_W-1:0]  select;
  logic              valid;
  logic              frame_start;
  logic              frame_end;
  logic              overrun;

  exp_t              q[$];
  logic [NUM_CH-1:0] fq[$];
  logic [NUM_CH-1:0] demux_lanes;
  int                n_vec = 0;
  int                n_err = 0;
  int                valid_cnt = 0;

  tdm_mux_16_1 #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
    .Clock_In        (clk),
    .Reset_In        (reset),
    .Enable_In       (enable),
    .Load_In         (load),
    .Data_In         (data_in),
    .Ready_Out       (ready),
    .Data_Out        (data_out),
    .Select_Out      (select),
    .Valid_Out       (valid),
    .Frame_Start_Out (frame_start),
    .Frame_End_Out   (frame_end),
    .Overrun_Out     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [NUM_CH-1:0] f);
    exp_t e;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      e.sel  = SEL_W'(k);
      e.data = f[k];
      e.fs   = (k == 0);
      e.fe   = (k == int'(NUM_CH) - 1);
      q.push_back(e);
    end
    fq.push_back(f);
  endtask

  // Issue a load that the bench expects to be accepted at the next edge.
  task automatic load_frame(input logic [NUM_CH-1:0] f);
    load    = 1'b1;
    data_in = f;
    push_frame(f);
    step();
    load    = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, 32'(q.size()), 32'd0);
    step();
  endtask

  // Monitor: per-slot scoreboard plus demux-style frame reconstruction.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (valid) begin
        valid_cnt++;
        chk("slot_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("select", 32'(select), 32'(e.sel));
          chk("data", 32'(data_out), 32'(e.data));
          chk("frame_start", 32'(frame_start), 32'(e.fs));
          chk("frame_end", 32'(frame_end), 32'(e.fe));
        end
        if (frame_start) demux_lanes = '0;
        demux_lanes[select] = data_out;
        if (frame_end && fq.size() != 0) begin
          chk("demux_frame", 32'(demux_lanes), 32'(fq.pop_front()));
        end
      end else begin
        chk("fs_without_valid", 32'(frame_start), 32'd0);
        chk("fe_without_valid", 32'(frame_end), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_CH-1:0] rnd;
    reset   = 1'b1;
    enable  = 1'b1;
    load    = 1'b0;
    data_in = '0;
    demux_lanes = '0;
    repeat (3) step();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_select", 32'(select), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_fe", 32'(frame_end), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    reset = 1'b0;
    step();
    step();
    chk("idle_ready", 32'(ready), 32'd1);

    // Single frame A5C3: LSB-first bits 1100_0011_1010_0101.
    valid_cnt = 0;
    load_frame(16'hA5C3);
    chk("first_slot_valid", 32'(valid), 32'd1);
    chk("first_slot_sel", 32'(select), 32'd0);
    chk("first_slot_data", 32'(data_out), 32'd1);
    drain("single");
    chk("single_after_valid", 32'(valid), 32'd0);
    chk("single_count", 32'(valid_cnt), 32'd16);

    // Back-to-back: FFFF then 0000 taken in slot 15.
    valid_cnt = 0;
    load_frame(16'hFFFF);
    for (int s = 0; s < 15; s++) begin
      chk("b2b_ready_low", 32'(ready), 32'd0);
      step();
    end
    chk("b2b_ready_slot15", 32'(ready), 32'd1);
    load_frame(16'h0000);
    chk("b2b_no_gap_valid", 32'(valid), 32'd1);
    chk("b2b_no_gap_sel", 32'(select), 32'd0);
    chk("b2b_no_gap_fs", 32'(frame_start), 32'd1);
    drain("b2b");
    chk("b2b_count", 32'(valid_cnt), 32'd32);

    // Pause three cycles at slot 7.
    valid_cnt = 0;
    load_frame(16'h3C5A);
    repeat (7) step();
    enable = 1'b0;
    for (int p = 0; p < 3; p++) begin
      step();
      chk("pause_valid", 32'(valid), 32'd0);
      chk("pause_sel", 32'(select), 32'd7);
    end
    enable = 1'b1;
    step();
    chk("resume_valid", 32'(valid), 32'd1);
    chk("resume_sel", 32'(select), 32'd8);
    drain("pause");
    chk("pause_count", 32'(valid_cnt), 32'd16);

    // Overrun: load 1234 at slot 4 must be dropped.
    valid_cnt = 0;
    load_frame(16'hBEEF);
    repeat (4) step();
    chk("ovr_ready", 32'(ready), 32'd0);
    load    = 1'b1;
    data_in = 16'h1234;
    step();
    load    = 1'b0;
    chk("ovr_pulse", 32'(overrun), 32'd1);
    step();
    chk("ovr_clear", 32'(overrun), 32'd0);
    drain("overrun");
    chk("ovr_count", 32'(valid_cnt), 32'd16);

    // Reset at slot 9 discards the rest of the frame.
    load_frame(16'hC0DE);
    repeat (9) step();
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd0);
    step();
    q.delete();
    fq.delete();
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_sel", 32'(select), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_fs_fe", 32'({frame_start, frame_end}), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ready), 32'd1);
    valid_cnt = 0;
    load_frame(16'h8001);
    chk("post_rst_sel", 32'(select), 32'd0);
    chk("post_rst_data", 32'(data_out), 32'd1);
    drain("post_rst");
    chk("post_rst_count", 32'(valid_cnt), 32'd16);

    // Loopback: 20 random frames back to back through the demux model.
    valid_cnt = 0;
    rnd = NUM_CH'($urandom);
    load_frame(rnd);
    for (int f = 1; f < 20; f++) begin
      repeat (15) step();
      rnd = NUM_CH'($urandom);
      load_frame(rnd);
    end
    drain("loopback");
    chk("loopback_count", 32'(valid_cnt), 32'd320);
    chk("frames_consumed", 32'(fq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
